// File: rtl/tex_texel_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tex_texel_fetch
// Description : Texel fetch stage of the texture unit. Turns one texel
//               coordinate request into a byte address (linear, 4x4-tiled
//               or ETC2/EAC block layout), reads the one or two 16-byte
//               lines that hold the texel and hands the texel bytes,
//               right-aligned and zero-extended to 128 bits, to the color
//               decoder together with the format code.
// Ports       : clk, rst_n (async, active low)
//               req_*   : request handshake + base/u/v/width_log2/format
//               mem_*   : 128-bit line read port, responses in order
//               out_*   : texel word handshake toward the decoder
//               cache_flush : invalidates the line cache when present
// Options     : TEX_FETCH_LINE_CACHE_EN - single-entry line cache that
//               lets a non-straddling request that hits skip memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tex_texel_fetch (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [31:0]  req_base,
    input  logic [11:0]  req_u,
    input  logic [11:0]  req_v,
    input  logic [3:0]   req_width_log2,
    input  logic [4:0]   req_format,
    input  logic         cache_flush,
    output logic         mem_req_valid,
    input  logic         mem_req_ready,
    output logic [31:0]  mem_addr,
    input  logic         mem_rsp_valid,
    input  logic [127:0] mem_rsp_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [4:0]   out_format
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALC  = 3'd1,
        S_REQ0  = 3'd2,
        S_WAIT0 = 3'd3,
        S_REQ1  = 3'd4,
        S_WAIT1 = 3'd5,
        S_OUT   = 3'd6
    } state_t;

    // Bytes occupied by one texel (or one compressed block) in memory.
    function automatic logic [4:0] f_bytes(input logic [4:0] fmt);
        logic [4:0] n;
        n = 5'd4;
        if (fmt[1:0] == 2'b01) n = 5'd2;
        case (fmt)
            5'b00000:                   n = 5'd3;
            5'b00100:                   n = 5'd4;
            5'b00011, 5'b00111:         n = 5'd4;  // 24-bit tiled is padded
            5'b01011, 5'b01111:         n = 5'd2;
            5'b10011:                   n = 5'd1;
            5'b10111:                   n = 5'd2;
            5'b00010, 5'b10010,
            5'b10110:                   n = 5'd8;
            5'b00110:                   n = 5'd16;
            default:                    ;
        endcase
        return n;
    endfunction

    // Pick n bytes starting at byte o of {l1, l0}; bytes above n are zero.
    function automatic logic [127:0] f_extract(input logic [127:0] l1,
                                               input logic [127:0] l0,
                                               input logic [3:0]   o,
                                               input logic [4:0]   n);
        logic [255:0] cat;
        logic [127:0] res;
        cat = {l1, l0} >> {o, 3'b000};
        res = cat[127:0];
        for (int k = 0; k < 16; k++) begin
            if (k >= {27'd0, n}) res[8*k +: 8] = 8'h00;
        end
        return res;
    endfunction

    state_t         r_state;
    logic [31:0]    r_base;
    logic [11:0]    r_u;
    logic [11:0]    r_v;
    logic [3:0]     r_wl;
    logic [4:0]     r_fmt;
    logic [31:0]    r_addr;
    logic [4:0]     r_n;
    logic           r_straddle;
    logic [127:0]   r_line0;
    logic           r_mem_req_valid;
    logic [31:0]    r_mem_addr;
    logic           r_out_valid;
    logic [127:0]   r_out_data;
    logic [4:0]     r_out_format;

`ifdef TEX_FETCH_LINE_CACHE_EN
    logic           r_cache_valid;
    logic [27:0]    r_cache_tag;
    logic [127:0]   r_cache_data;
    logic           w_hit;
`else
    logic           w_unused;
    assign w_unused = cache_flush;
`endif

    logic [4:0]     w_n;
    logic [11:0]    w_umask;
    logic [11:0]    w_u_m;
    logic [31:0]    w_trow;
    logic [31:0]    w_tile;
    logic [31:0]    w_idx;
    logic [31:0]    w_off;
    logic [31:0]    w_addr;
    logic           w_straddle;

    // Address arithmetic works on the request fields captured at accept
    // time and is registered at the end of CALC.
    always_comb begin
        w_n     = f_bytes(r_fmt);
        w_umask = (12'd1 << r_wl) - 12'd1;
        w_u_m   = r_u & w_umask;
        // (v>>2) * (width>>2); width below 4 has no whole tile columns.
        w_trow  = (r_wl < 4'd2) ? 32'd0 : ({22'd0, r_v[11:2]} << (r_wl - 4'd2));
        w_tile  = w_trow + {22'd0, w_u_m[11:2]};
        case (r_fmt[1:0])
            2'b11:   w_idx = {w_tile[27:0], r_v[1:0], w_u_m[1:0]};
            2'b10:   w_idx = w_tile;
            default: w_idx = ({20'd0, r_v} << r_wl) + {20'd0, w_u_m};
        endcase
        w_off      = w_idx * {27'd0, w_n};
        w_addr     = r_base + w_off;
        w_straddle = ({2'b00, w_addr[3:0]} + {1'b0, w_n}) > 6'd16;
    end

`ifdef TEX_FETCH_LINE_CACHE_EN
    // A flush arriving during CALC is treated as already applied.
    assign w_hit = r_cache_valid && !cache_flush && !w_straddle &&
                   (r_cache_tag == w_addr[31:4]);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_base          <= 32'd0;
            r_u             <= 12'd0;
            r_v             <= 12'd0;
            r_wl            <= 4'd0;
            r_fmt           <= 5'd0;
            r_addr          <= 32'd0;
            r_n             <= 5'd0;
            r_straddle      <= 1'b0;
            r_line0         <= 128'd0;
            r_mem_req_valid <= 1'b0;
            r_mem_addr      <= 32'd0;
            r_out_valid     <= 1'b0;
            r_out_data      <= 128'd0;
            r_out_format    <= 5'd0;
`ifdef TEX_FETCH_LINE_CACHE_EN
            r_cache_valid   <= 1'b0;
            r_cache_tag     <= 28'd0;
            r_cache_data    <= 128'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_base  <= req_base;
                        r_u     <= req_u;
                        r_v     <= req_v;
                        r_wl    <= req_width_log2;
                        r_fmt   <= req_format;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_addr     <= w_addr;
                    r_n        <= w_n;
                    r_straddle <= w_straddle;
`ifdef TEX_FETCH_LINE_CACHE_EN
                    if (w_hit) begin
                        r_out_data   <= f_extract(128'd0, r_cache_data, w_addr[3:0], w_n);
                        r_out_format <= r_fmt;
                        r_out_valid  <= 1'b1;
                        r_state      <= S_OUT;
                    end else
`endif
                    begin
                        r_mem_addr      <= {w_addr[31:4], 4'b0000};
                        r_mem_req_valid <= 1'b1;
                        r_state         <= S_REQ0;
                    end
                end
                S_REQ0, S_REQ1: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= (r_state == S_REQ0) ? S_WAIT0 : S_WAIT1;
                    end
                end
                S_WAIT0: begin
                    if (mem_rsp_valid) begin
`ifdef TEX_FETCH_LINE_CACHE_EN
                        r_cache_valid <= 1'b1;
                        r_cache_tag   <= r_mem_addr[31:4];
                        r_cache_data  <= mem_rsp_data;
`endif
                        if (r_straddle) begin
                            r_line0         <= mem_rsp_data;
                            r_mem_addr      <= {r_addr[31:4] + 28'd1, 4'b0000};
                            r_mem_req_valid <= 1'b1;
                            r_state         <= S_REQ1;
                        end else begin
                            r_out_data   <= f_extract(128'd0, mem_rsp_data, r_addr[3:0], r_n);
                            r_out_format <= r_fmt;
                            r_out_valid  <= 1'b1;
                            r_state      <= S_OUT;
                        end
                    end
                end
                S_WAIT1: begin
                    if (mem_rsp_valid) begin
`ifdef TEX_FETCH_LINE_CACHE_EN
                        r_cache_valid <= 1'b1;
                        r_cache_tag   <= r_mem_addr[31:4];
                        r_cache_data  <= mem_rsp_data;
`endif
                        r_out_data   <= f_extract(mem_rsp_data, r_line0, r_addr[3:0], r_n);
                        r_out_format <= r_fmt;
                        r_out_valid  <= 1'b1;
                        r_state      <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
`ifdef TEX_FETCH_LINE_CACHE_EN
            // Placed last so a flush overrides a fill on the same edge.
            if (cache_flush) r_cache_valid <= 1'b0;
`endif
        end
    end

    assign req_ready     = (r_state == S_IDLE);
    assign mem_req_valid = r_mem_req_valid;
    assign mem_addr      = r_mem_addr;
    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_format    = r_out_format;

endmodule
`default_nettype wire

// File: tb/tb_tex_texel_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_tex_texel_fetch
// Description : Self-checking bench for tex_texel_fetch. A behavioural
//               memory returns lines whose bytes are a hash of their
//               address; a reference model derives texel address, bytes,
//               expected line reads and latency from coordinates.
//               Honours TEX_FETCH_LINE_CACHE_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tex_texel_fetch;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_base;
    logic [11:0]  req_u;
    logic [11:0]  req_v;
    logic [3:0]   req_width_log2;
    logic [4:0]   req_format;
    logic         cache_flush;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  mem_addr;
    logic         mem_rsp_valid;
    logic [127:0] mem_rsp_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [4:0]   out_format;

    always #5 clk = ~clk;

    tex_texel_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_base       (req_base),
        .req_u          (req_u),
        .req_v          (req_v),
        .req_width_log2 (req_width_log2),
        .req_format     (req_format),
        .cache_flush    (cache_flush),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_format     (out_format)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // memory responder controls
    int stall_left  = 0;
    int rsp_lat     = 0;
    bit inject_late = 0;

    // reference cache state
    bit          m_cvalid = 0;
    logic [31:0] m_ctag   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h9E3779B1;
        return h[31:24] ^ a[7:0];
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] la);
        logic [127:0] l;
        for (int k = 0; k < 16; k++) l[8*k +: 8] = mem_byte(la + 32'(k));
        return l;
    endfunction

    function automatic int ref_bytes(input logic [4:0] f);
        case (f)
            5'b00000:                     return 3;
            5'b00100:                     return 4;
            5'b00011, 5'b00111:           return 4;
            5'b01011, 5'b01111:           return 2;
            5'b10011:                     return 1;
            5'b10111:                     return 2;
            5'b00010, 5'b10010, 5'b10110: return 8;
            5'b00110:                     return 16;
            default:                      return (f[1:0] == 2'b01) ? 2 : 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_addr(input logic [31:0] base, input int u, input int v,
                                             input int wl, input logic [4:0] f);
        longint w, up, n, off;
        w  = longint'(1) << wl;
        up = u % w;
        n  = ref_bytes(f);
        case (f[1:0])
            2'b11:   off = (((v / 4) * (w / 4) + up / 4) * 16 + (v % 4) * 4 + up % 4) * n;
            2'b10:   off = ((v / 4) * (w / 4) + up / 4) * n;
            default: off = (v * w + up) * n;
        endcase
        return base + off[31:0];
    endfunction

    // Memory: one read outstanding, response rsp_lat cycles after accept.
    initial begin : g_responder
        bit hs, stl, pending;
        logic [31:0] ha, paddr;
        int dly;
        pending = 0; dly = 0; paddr = 0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            hs  = mem_req_valid && mem_req_ready;
            stl = mem_req_valid && !mem_req_ready;
            ha  = mem_addr;
            @(posedge clk);
            #1;
            mem_rsp_valid = 1'b0;
            if (stl && stall_left > 0) stall_left--;
            if (!rst_n) begin
                pending = 0;
            end else begin
                if (hs) begin pending = 1; paddr = ha; dly = rsp_lat; end
                if (pending) begin
                    if (dly == 0) begin
                        mem_rsp_valid = 1'b1;
                        mem_rsp_data  = mem_line(paddr);
                        pending = 0;
                    end else dly--;
                end
                if (inject_late) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = {4{32'hDEADBEEF}};
                    inject_late   = 0;
                end
            end
            mem_req_ready = (stall_left == 0);
        end
    end

    task automatic run_txn(input logic [31:0] base, input logic [11:0] u, input logic [11:0] v,
                           input logic [3:0] wl, input logic [4:0] fmt,
                           input int stall, input int lat, input int hold,
                           input logic [31:0] want_l0, input bit use_want);
        int n, explat, cyc, to;
        logic [31:0] a, l0;
        bit strad, hit;
        logic [127:0] expd, d;
        logic [31:0] expq[$];
        logic [31:0] obsq[$];
        logic pv, pr;
        logic [31:0] pa;

        n     = ref_bytes(fmt);
        a     = ref_addr(base, int'(u), int'(v), int'(wl), fmt);
        l0    = {a[31:4], 4'h0};
        strad = (int'(a[3:0]) + n) > 16;
        expd  = '0;
        for (int k = 0; k < n; k++) expd[8*k +: 8] = mem_byte(a + 32'(k));
        hit = 0;
`ifdef TEX_FETCH_LINE_CACHE_EN
        hit = m_cvalid && !strad && (m_ctag == l0);
`endif
        if (!hit) begin
            expq.push_back(l0);
            if (strad) expq.push_back(l0 + 32'd16);
            m_cvalid = 1;
            m_ctag   = expq[expq.size()-1];
        end
        explat = hit ? 2 : (strad ? 6 + stall + 2 * lat : 4 + stall + lat);

        stall_left     = stall;
        rsp_lat        = lat;
        req_base       = base;
        req_u          = u;
        req_v          = v;
        req_width_log2 = wl;
        req_format     = fmt;
        req_valid      = 1'b1;
        to = 0;
        while (!req_ready && to < 50) begin @(negedge clk); to++; end
        chk("req_ready_wait", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        pv = 0; pr = 0; pa = 0;
        while (!out_valid && cyc < 300) begin
            if (pv && !pr) begin
                chk("memreq_valid_held", mem_req_valid, 1'b1);
                chk("memreq_addr_held", mem_addr, pa);
            end
            if (mem_req_valid && mem_req_ready) obsq.push_back(mem_addr);
            pv = mem_req_valid; pr = mem_req_ready; pa = mem_addr;
            @(negedge clk);
            cyc++;
        end
        chk("out_valid_seen", out_valid, 1'b1);
        chk("latency", cyc, explat);
        chk("num_reads", obsq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < obsq.size(); i++) chk("read_addr", obsq[i], expq[i]);
        if (use_want && obsq.size() > 0) chk("line0_addr", obsq[0], want_l0);
        chk("out_data", out_data, expd);
        chk("out_format", out_format, fmt);

        for (int i = 0; i < hold; i++) begin
            d = out_data;
            @(negedge clk);
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_data", out_data, d);
            chk("hold_req_ready", req_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_out_valid", out_valid, 1'b0);
        chk("post_req_ready", req_ready, 1'b1);
    endtask

    initial begin
        logic [4:0] fmts [14];
        logic [31:0] b;
        fmts = '{5'b00000, 5'b00100, 5'b00001, 5'b01101, 5'b00011, 5'b00111, 5'b01011,
                 5'b01111, 5'b10011, 5'b10111, 5'b00010, 5'b10010, 5'b10110, 5'b00110};
        rst_n = 1'b0; req_valid = 1'b0; req_base = 0; req_u = 0; req_v = 0;
        req_width_log2 = 0; req_format = 0; cache_flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_out_format", out_format, 5'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // directed cases
        run_txn(32'h1000, 12'd3,  12'd2, 4'd4, 5'b00100, 0, 0, 0, 32'h1080, 1);
        run_txn(32'h1000, 12'd5,  12'd0, 4'd4, 5'b00000, 0, 0, 0, 32'h1000, 1);
        run_txn(32'h1000, 12'd21, 12'd6, 4'd4, 5'b01111, 0, 0, 0, 32'h10B0, 1);
        run_txn(32'h1000, 12'd9,  12'd5, 4'd4, 5'b00110, 0, 0, 0, 32'h1060, 1);
        run_txn(32'h1000, 12'd9,  12'd5, 4'd4, 5'b00010, 0, 0, 0, 32'h1030, 1);
        // backpressure on the memory port and on the output
        run_txn(32'h2000, 12'd7,  12'd3, 4'd5, 5'b00100, 5, 1, 3, 32'h0, 0);
        // straddle that wraps past the top of the address space
        run_txn(32'hFFFFFFFE, 12'd0, 12'd0, 4'd2, 5'b00100, 0, 0, 0, 32'hFFFFFFF0, 1);

        // random requests
        for (int t = 0; t < 40; t++) begin
            b = $urandom;
            if (t % 8 == 3) b = 32'hFFFFFF00 | 32'($urandom_range(0, 255));
            run_txn(b, 12'($urandom), 12'($urandom), 4'($urandom_range(2, 11)),
                    (t % 5 == 4) ? 5'($urandom) : fmts[$urandom_range(0, 13)],
                    $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2), 32'h0, 0);
        end

        // reset while waiting for the first response
        rsp_lat = 4; stall_left = 0;
        req_base = 32'h3000; req_u = 12'd1; req_v = 12'd1; req_width_log2 = 4'd3;
        req_format = 5'b00100; req_valid = 1'b1;
        @(negedge clk);                 // accepted
        req_valid = 1'b0;
        repeat (2) @(negedge clk);      // cycle 3: waiting for response
        chk("wait0_mem_idle", mem_req_valid, 1'b0);
        chk("wait0_no_out", out_valid, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mrst_req_ready", req_ready, 1'b1);
        chk("mrst_mem_req_valid", mem_req_valid, 1'b0);
        chk("mrst_mem_addr", mem_addr, 32'd0);
        chk("mrst_out_valid", out_valid, 1'b0);
        chk("mrst_out_data", out_data, 128'd0);
        chk("mrst_out_format", out_format, 5'd0);
        m_cvalid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        inject_late = 1;
        rsp_lat = 0;
        repeat (4) begin
            @(negedge clk);
            chk("late_rsp_out_valid", out_valid, 1'b0);
            chk("late_rsp_req_ready", req_ready, 1'b1);
            chk("late_rsp_mem_req", mem_req_valid, 1'b0);
        end
        run_txn(32'h1000, 12'd3, 12'd2, 4'd4, 5'b00100, 0, 0, 0, 32'h1080, 1);

`ifdef TEX_FETCH_LINE_CACHE_EN
        // the repeat hits; after a flush the line is fetched again
        run_txn(32'h1000, 12'd3, 12'd2, 4'd4, 5'b00100, 0, 0, 0, 32'h1080, 0);
        cache_flush = 1'b1;
        @(negedge clk);
        cache_flush = 1'b0;
        m_cvalid = 0;
        run_txn(32'h1000, 12'd3, 12'd2, 4'd4, 5'b00100, 0, 0, 0, 32'h1080, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tex_texel_fetch.md
# tex_texel_fetch

Texel fetch stage of the texture unit, directly upstream of the texture color decoder. Accepts one texel coordinate request and computes the byte address for linear, 4x4-tiled, or ETC2/EAC block-compressed layouts. Issues one or two 128-bit line reads to the memory port and delivers the texel (or compressed block) right-aligned in a 128-bit word, together with its 5-bit format code, for the decoder.

## Interface
- (no parameters; line size fixed at 16 bytes, address width 32)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block accepts request (high only in IDLE)
- req_base  in  32  texture base byte address
- req_u, req_v  in  12 each  texel coordinates
- req_width_log2  in  4  texture width = 1<<req_width_log2 (2..11 legal)
- req_format  in  5  format code, decoder encoding (bits[1:0] = class)
- cache_flush  in  1  invalidate line cache (ignored without cache)
- mem_req_valid  out  1  line read request
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  32  16-byte-aligned line address (bits[3:0]=0)
- mem_rsp_valid  in  1  read data valid, in request order
- mem_rsp_data  in  128  line data, byte k at bits[8k+7:8k]
- out_valid  out  1  texel word valid
- out_ready  in  1  decoder accepts
- out_data  out  128  texel bytes at bits[8*n-1:0], upper bits zero
- out_format  out  5  req_format of this texel

## Operation
- Bytes per texel n: 00000 → 3; 00100 → 4; class 01 → 2; 00011/00111 → 4 (24-bit tiled stored padded); 01011/01111 → 2; 10011 → 1; 10111 → 2. Compressed: 00010, 10010, 10110 → 8-byte block; 00110 → 16-byte block. Other codes: n=4.
- u' = req_u & (width-1). v is not masked.
- Linear (class 00/01): off = (v*width + u')*n.
- Tiled (class 11): off = (((v>>2)*(width>>2) + (u'>>2))*16 + (v&3)*4 + (u'&3))*n.
- Compressed (class 10): off = ((v>>2)*(width>>2) + (u'>>2))*n.
- addr = req_base + off, modulo 2^32. line0 = addr & ~15; o = addr[3:0].
- Straddle when o + n > 16; second read at line0 + 16 (wraps modulo 2^32).
- Result = n bytes from concat{line1, line0} starting at byte o; bytes n..15 zero.
- FSM: IDLE → (req handshake) CALC → REQ0 → WAIT0 → [REQ1 → WAIT1 if straddle] → OUT → (out handshake) IDLE.
- CALC registers addr, n, straddle flag; one cycle. REQx holds mem_req_valid and mem_addr until mem_req_ready. WAITx captures mem_rsp_valid data.
- mem_rsp_valid outside WAIT0/WAIT1 is ignored.
- Reset values: state IDLE, req_ready 1 (combinational from IDLE), mem_req_valid 0, mem_addr 0, out_valid 0, out_data 0, out_format 0, cache invalid.
- Reset mid-transaction returns to IDLE and drops the transaction. The memory port must be reset in the same domain, so no stale response is delivered.

## Timing
- Request accepted at edge E0. CALC in cycle 1. mem_req_valid asserts in cycle 2.
- Response earliest in the cycle after the request handshake. out_valid asserts the cycle after the last response is captured.
- Minimum latency with zero-wait memory: 4 cycles non-straddle, 6 cycles straddle.
- out_data/out_format stable while out_valid and !out_ready. The next req_ready is the cycle after the out handshake. Throughput is one request in flight.
- mem_req_valid never drops before mem_req_ready. At most one outstanding read.

## Configuration
- TEX_FETCH_LINE_CACHE_EN defined: single-entry cache (tag line address + valid bit).
  - Filled on every response capture, including the second line of a straddle.
  - Invalidated by reset and by cache_flush high on any edge. A flush in the same cycle as a fill wins.
  - A non-straddle request whose line0 matches a valid tag goes CALC → OUT with no memory read: out_valid at cycle 2.
  - Straddle requests always read both lines.
- Undefined: no cache storage, cache_flush ignored, every request reads memory.

## Test plan
- RGBA_32 (00100), base 0x1000, width_log2 4, u=3, v=2 → mem_addr 0x1080; out_data[31:0] = line bytes 12..15; bits[127:32] = 0; latency 4 with zero-wait memory.
- RGB_24 (00000), base 0x1000, width_log2 4, u=5, v=0 → reads 0x1000 then 0x1010; out_data[23:0] = {L1.byte1, L1.byte0, L0.byte15}.
- RGBA_16_TILED (01111), base 0x1000, width_log2 4, u=21, v=6 → u'=5, offset 0xB2, mem_addr 0x10B0; out_data[15:0] = bytes 2..3.
- Compressed 00110, u=9, v=5 → mem_addr 0x1060, out_data = full line. Format 00010, same u, v → mem_addr 0x1030, out_data[63:0] = bytes 0..7.
- Backpressure:
  - mem_req_ready low 5 cycles: mem_req_valid and mem_addr stay constant.
  - out_ready low 3 cycles: out_data stable and req_ready stays 0.
  - rst_n pulsed in WAIT0 → all outputs at reset values; the late mem_rsp_valid is ignored.
- With TEX_FETCH_LINE_CACHE_EN: repeat the first test → no mem_req_valid, out_valid at cycle 2. Pulse cache_flush, then repeat → memory read reissued.
